multi_channel_up_down_counter: RTL and testbench

//  Parametrised successor to the single 8-bit up/down accumulating counter: N independent channels,

---
 rtl/multi_channel_up_down_counter_pkg.sv | 19 +
 rtl/multi_channel_up_down_counter_ch.sv | 84 ++++++++
 rtl/multi_channel_up_down_counter.sv | 48 ++++
 tb/tb_multi_channel_up_down_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_up_down_counter_pkg.sv
// Shared constants and helpers for the multi-channel up/down counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package multi_channel_up_down_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // All-ones value of a w-bit count; callers truncate to their own width.
  function automatic logic [63:0] max_val(input int unsigned w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/multi_channel_up_down_counter_ch.sv
// Single counter lane: accumulator with wrap/saturate clamp, overflow pulse and sticky threshold hit.
// Latency: 1 cycle from sampled inputs to registered count/ovf/hit.
// Backpressure: none; every edge applies clr > load > en > hold.
module up_down_counter_ch
  import multi_channel_up_down_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sat_mode,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] add_val,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  threshold,
  output logic [WIDTH-1:0]  count,
  output logic              ovf,
  output logic              hit
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(max_val(WIDTH));

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             hit_q, hit_d;
  logic [WIDTH:0]   sum;

  // One extra bit holds the carry (add) or borrow (subtract) out of the count width.
  always_comb begin
    if (up_down == DIR_DOWN) begin
      sum = {1'b0, count_q} - (WIDTH+1)'(add_val);
    end else begin
      sum = {1'b0, count_q} + (WIDTH+1)'(add_val);
    end
  end

  // Next-state selection: clear beats load beats accumulate beats hold.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    hit_d   = hit_q;
    if (clr) begin
      count_d = '0;
      hit_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
      hit_d   = hit_q | (load_val == threshold);
    end else if (en) begin
      if (sum[WIDTH]) begin
        ovf_d = 1'b1;
        if (sat_mode == MODE_SAT) begin
          count_d = (up_down == DIR_DOWN) ? '0 : CNT_MAX;
        end else begin
          count_d = sum[WIDTH-1:0];
        end
      end else begin
        count_d = sum[WIDTH-1:0];
      end
      hit_d = hit_q | (count_d == threshold);
    end
  end

  // State registers with synchronous reset that discards any pending update.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      hit_q   <= hit_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign hit   = hit_q;

endmodule

// File: rtl/multi_channel_up_down_counter.sv
// N independent up/down accumulating counters sharing mode, load value and threshold.
// Latency: 1 cycle; all outputs registered inside the lanes.
// Backpressure: none; inputs are consumed every clock edge.
module multi_channel_up_down_counter
  import multi_channel_up_down_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 8,
  parameter int CHANNELS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       satMode,
  input  logic [CHANNELS-1:0]        en,
  input  logic [CHANNELS-1:0]        upDown,
  input  logic [CHANNELS*STEP_W-1:0] addVal,
  input  logic [CHANNELS-1:0]        clr,
  input  logic [CHANNELS-1:0]        load,
  input  logic [WIDTH-1:0]           loadVal,
  input  logic [WIDTH-1:0]           threshold,
  output logic [CHANNELS*WIDTH-1:0]  count,
  output logic [CHANNELS-1:0]        ovf,
  output logic [CHANNELS-1:0]        hit
);

  // One lane per channel; the top only slices the packed buses.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    up_down_counter_ch #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sat_mode  (satMode),
      .en        (en[i]),
      .up_down   (upDown[i]),
      .add_val   (addVal[i*STEP_W +: STEP_W]),
      .clr       (clr[i]),
      .load      (load[i]),
      .load_val  (loadVal),
      .threshold (threshold),
      .count     (count[i*WIDTH +: WIDTH]),
      .ovf       (ovf[i]),
      .hit       (hit[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_up_down_counter.sv
// Self-checking bench: integer reference model compared every cycle, plus directed literal checks.
// Latency: model expects outputs one edge after inputs are sampled.
// Backpressure: none; stimulus changes 2 time units after each rising edge.
module tb_multi_channel_up_down_counter;

  localparam int W  = 8;
  localparam int SW = 8;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              satMode;
  logic [CH-1:0]     en, upDown, clr, load;
  logic [CH*SW-1:0]  addVal;
  logic [W-1:0]      loadVal, threshold;
  logic [CH*W-1:0]   count;
  logic [CH-1:0]     ovf, hit;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers).
  int m_cnt [CH];
  bit m_ovf [CH];
  bit m_hit [CH];
  bit model_valid = 1'b0;

  multi_channel_up_down_counter #(.WIDTH(W), .STEP_W(SW), .CHANNELS(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .satMode   (satMode),
    .en        (en),
    .upDown    (upDown),
    .addVal    (addVal),
    .clr       (clr),
    .load      (load),
    .loadVal   (loadVal),
    .threshold (threshold),
    .count     (count),
    .ovf       (ovf),
    .hit       (hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dut_cnt(input int c);
    return int'(count[c*W +: W]);
  endfunction

  task automatic set_add(input int c, input int v);
    addVal[c*SW +: SW] = SW'(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model update at each edge from the inputs sampled there, then compare just after the edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_cnt[c] = 0; m_ovf[c] = 0; m_hit[c] = 0;
      end
      model_valid = 1'b1;
    end else if (model_valid) begin
      for (int c = 0; c < CH; c++) begin
        int a, s;
        a = int'(addVal[c*SW +: SW]);
        if (clr[c]) begin
          m_cnt[c] = 0; m_ovf[c] = 0; m_hit[c] = 0;
        end else if (load[c]) begin
          m_cnt[c] = int'(loadVal); m_ovf[c] = 0;
          if (m_cnt[c] == int'(threshold)) m_hit[c] = 1;
        end else if (en[c]) begin
          s = upDown[c] ? m_cnt[c] - a : m_cnt[c] + a;
          if (s > 255 || s < 0) begin
            m_ovf[c] = 1;
            if (satMode) m_cnt[c] = (s > 255) ? 255 : 0;
            else         m_cnt[c] = (s + 256) % 256;
          end else begin
            m_ovf[c] = 0;
            m_cnt[c] = s;
          end
          if (m_cnt[c] == int'(threshold)) m_hit[c] = 1;
        end else begin
          m_ovf[c] = 0;
        end
      end
    end
    #1;
    if (model_valid) begin
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("model_count%0d", c), dut_cnt(c), m_cnt[c]);
        chk($sformatf("model_ovf%0d", c), ovf[c], m_ovf[c]);
        chk($sformatf("model_hit%0d", c), hit[c], m_hit[c]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held 3 cycles while enables are active
    reset = 1; satMode = 0; en = '1; upDown = '0; clr = '0; load = '0;
    loadVal = '0; threshold = 8'd200;
    for (int c = 0; c < CH; c++) set_add(c, 1);
    repeat (3) tick();
    chk("reset_count", count, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_hit", hit, 0);
    reset = 0;
    tick();
    chk("release_count", count, 32'h01010101);

    // 2: ch0 accumulate then wrap below zero
    en = '0; clr = '1; tick(); clr = '0;
    en = 4'b0001;
    set_add(0, 1); repeat (2) tick();
    set_add(0, 2); repeat (5) tick();
    chk("acc_count0", dut_cnt(0), 12);
    upDown[0] = 1; set_add(0, 1);
    repeat (12) tick();
    chk("down_to_zero", dut_cnt(0), 0);
    chk("down_to_zero_ovf", ovf[0], 0);
    tick();
    chk("wrap_count0", dut_cnt(0), 255);
    chk("wrap_ovf0", ovf[0], 1);
    en = '0; tick();
    chk("wrap_ovf0_pulse_end", ovf[0], 0);

    // 3: saturate ch2
    satMode = 1; upDown = '0;
    loadVal = 8'd250; load = 4'b0100; tick(); load = '0;
    en = 4'b0100; set_add(2, 10); tick();
    chk("sat_up_count2", dut_cnt(2), 255);
    chk("sat_up_ovf2", ovf[2], 1);
    tick();
    chk("sat_up2_count2", dut_cnt(2), 255);
    chk("sat_up2_ovf2", ovf[2], 1);
    en = '0; loadVal = 8'd3; load = 4'b0100; tick(); load = '0;
    en = 4'b0100; upDown[2] = 1; set_add(2, 5); tick();
    chk("sat_dn_count2", dut_cnt(2), 0);
    chk("sat_dn_ovf2", ovf[2], 1);
    set_add(2, 0); tick();
    chk("add0_count2", dut_cnt(2), 0);
    chk("add0_ovf2", ovf[2], 0);
    en = '0; upDown = '0;

    // 4: priority on ch1
    satMode = 0; loadVal = 8'd77; set_add(1, 5);
    clr = 4'b0010; load = 4'b0010; en = 4'b0010; tick();
    chk("prio_clr", dut_cnt(1), 0);
    clr = '0; tick();
    chk("prio_load", dut_cnt(1), 77);
    load = '0; tick();
    chk("prio_en", dut_cnt(1), 82);
    en = '0;

    // 5: sticky hit on ch3
    threshold = 8'd20; clr = 4'b1000; tick(); clr = '0;
    en = 4'b1000; set_add(3, 4);
    repeat (4) tick();
    chk("hit_before", hit[3], 0);
    tick();
    chk("hit_at20_count", dut_cnt(3), 20);
    chk("hit_at20", hit[3], 1);
    repeat (2) tick();
    chk("hit_at28_count", dut_cnt(3), 28);
    chk("hit_at28", hit[3], 1);
    en = '0; threshold = 8'd99; tick();
    chk("hit_thr_change", hit[3], 1);
    clr = 4'b1000; tick(); clr = '0;
    chk("hit_clr", hit[3], 0);
    chk("hit_clr_count", dut_cnt(3), 0);
    threshold = 8'd20; loadVal = 8'd20; load = 4'b1000; tick(); load = '0;
    chk("hit_load", hit[3], 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      satMode   = 1'($urandom_range(0, 1));
      en        = 4'($urandom);
      upDown    = 4'($urandom);
      clr       = '0;
      load      = '0;
      for (int c = 0; c < CH; c++) begin
        clr[c]  = ($urandom_range(0, 15) == 0);
        load[c] = ($urandom_range(0, 11) == 0);
        set_add(c, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6));
      end
      loadVal   = 8'($urandom);
      threshold = 8'($urandom_range(0, 31));
      reset     = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 0; clr = '0; load = '0;

    // 6: reset mid-operation with overflow pending, then lane independence
    satMode = 0; upDown = '0; en = '1;
    for (int c = 0; c < CH; c++) set_add(c, 200);
    repeat (2) tick();
    reset = 1; tick(); reset = 0;
    chk("mid_reset_count", count, 0);
    chk("mid_reset_ovf", ovf, 0);
    chk("mid_reset_hit", hit, 0);
    en = 4'b0001; set_add(0, 3); threshold = 8'd100; tick();
    chk("indep_count0", dut_cnt(0), 3);
    chk("indep_others", count[CH*W-1:W], 0);
    en = '0; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
